// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that shares one external WIDTH-bit adder
// among NREQ requesters and returns each sum, tagged with its owner, on a registered valid/ready channel.
module adder_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] op_a,
   input  logic [NREQ*WIDTH-1:0] op_b,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      add_a,
   output logic [WIDTH-1:0]      add_b,
   input  logic [WIDTH-1:0]      add_y,
   output logic                  res_valid,
   output logic [1:0]            res_id,
   output logic [WIDTH-1:0]      res_data,
   input  logic                  res_ready
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       res_id_q, res_id_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;

   logic             issue_en_s;
   logic             grant_s;
   logic [1:0]       gidx_s;
   logic [NREQ-1:0]  gnt_s;
   logic [WIDTH-1:0] add_a_s, add_b_s;

   // Index base+offs folded back into 0..NREQ-1 (base is always < NREQ).
   function automatic int wrap_idx(input logic [1:0] base, input int offs);
      int s;
      s = int'(base) + offs;
      return (s >= NREQ) ? (s - NREQ) : s;
   endfunction

   // A new grant may only issue when the result slot is free or being drained this edge.
   assign issue_en_s = rst_n && ((state_q == ST_EMPTY) || res_ready);

   // Round-robin search starting at ptr_q; the first requesting index wins.
   always_comb begin
      logic hit;
      gnt_s   = '0;
      grant_s = 1'b0;
      gidx_s  = 2'd0;
      hit     = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            hit      = issue_en_s && !grant_s && req[i] && (wrap_idx(ptr_q, k) == i);
            gnt_s[i] = gnt_s[i] | hit;
            gidx_s   = hit ? 2'(i) : gidx_s;
            grant_s  = grant_s | hit;
         end
      end
   end

   // Steer the granted requester's operands onto the shared adder; zero when idle.
   always_comb begin
      add_a_s = '0;
      add_b_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         add_a_s = add_a_s | ({WIDTH{gnt_s[i]}} & op_a[i*WIDTH +: WIDTH]);
         add_b_s = add_b_s | ({WIDTH{gnt_s[i]}} & op_b[i*WIDTH +: WIDTH]);
      end
   end

   // Next-state logic for the result slot, pointer and result payload.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      res_id_d   = res_id_q;
      res_data_d = res_data_q;
      case (state_q)
         ST_EMPTY: begin
            if (grant_s) begin
               state_d = ST_FULL;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (grant_s) begin
               state_d = ST_FULL;
            end else if (res_ready) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_FULL;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Payload and pointer only move with a grant; a plain drain leaves them as they were.
      if (grant_s) begin
         ptr_d      = 2'(wrap_idx(gidx_s, 1));
         res_id_d   = gidx_s;
         res_data_d = add_y;
      end else begin
         ptr_d      = ptr_q;
         res_id_d   = res_id_q;
         res_data_d = res_data_q;
      end
   end

   // State, pointer and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         ptr_q      <= 2'd0;
         res_id_q   <= 2'd0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         res_id_q   <= res_id_d;
         res_data_q <= res_data_d;
      end
   end

   assign gnt       = gnt_s;
   assign add_a     = add_a_s;
   assign add_b     = add_b_s;
   assign res_valid = (state_q == ST_FULL);
   assign res_id    = res_id_q;
   assign res_data  = res_data_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus randomized traffic checked
// against a queue-free behavioural model of the round-robin arbiter and result slot.
module tb_adder_arbiter;
   localparam int WIDTH = 8;
   localparam int NREQ  = 3;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] op_a, op_b;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      add_a, add_b, add_y;
   logic                  res_valid;
   logic [1:0]            res_id;
   logic [WIDTH-1:0]      res_data;
   logic                  res_ready;

   int         n_vec = 0;
   int         n_err = 0;
   int         m_ptr;
   bit         m_valid;
   int         m_id;
   logic [7:0] m_data;
   int         gdum;

   always #5 clk = ~clk;

   // The shared adder lives outside the arbiter.
   assign add_y = add_a + add_b;

   adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
      .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_y(add_y),
      .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
      .res_ready(res_ready)
   );

   function automatic logic [7:0] opa(input int i);
      return op_a[i*WIDTH +: WIDTH];
   endfunction

   function automatic logic [7:0] opb(input int i);
      return op_b[i*WIDTH +: WIDTH];
   endfunction

   // Which requester the specification says wins this cycle, or -1.
   function automatic int exp_grant();
      int idx;
      if (m_valid && !res_ready) return -1;
      for (int k = 0; k < NREQ; k++) begin
         idx = (m_ptr + k) % NREQ;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int g);
      logic [NREQ-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = 1'b0;
      m_id    = 0;
      m_data  = 8'h00;
   endtask

   // Advance one clock edge and apply the same edge to the model.
   task automatic tick(output int g);
      g = exp_grant();
      @(posedge clk);
      if (g >= 0) begin
         m_data  = opa(g) + opb(g);
         m_id    = g;
         m_valid = 1'b1;
         m_ptr   = (g + 1) % NREQ;
      end else if (m_valid && res_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic reset_dut();
      rst_n     = 1'b0;
      req       = '0;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
      op_a[i*WIDTH +: WIDTH] = a;
      op_b[i*WIDTH +: WIDTH] = b;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req       = 3'b111;
      res_ready = 1'b1;
      op_a      = 24'h030201;
      op_b      = 24'h030201;
      #1;
      n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt got %b want 000", gnt); end
      n_vec++; if (add_a !== 8'h00 || add_b !== 8'h00) begin n_err++; $display("FAIL reset_add got %h/%h want 00/00", add_a, add_b); end
      n_vec++; if (res_valid !== 1'b0 || res_id !== 2'd0 || res_data !== 8'h00) begin
         n_err++; $display("FAIL reset_res got v=%b id=%0d d=%h want 0/0/00", res_valid, res_id, res_data); end
      reset_dut();
   endtask

   task automatic test_single();
      reset_dut();
      set_ops(0, 8'h12, 8'h34);
      req = 3'b001;
      #1;
      n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL single_gnt got %b want 001", gnt); end
      n_vec++; if (add_a !== 8'h12 || add_b !== 8'h34) begin n_err++; $display("FAIL single_add got %h/%h want 12/34", add_a, add_b); end
      tick(gdum);
      req = 3'b000;
      n_vec++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 8'h46) begin
         n_err++; $display("FAIL single_res got v=%b id=%0d d=%h want 1/0/46", res_valid, res_id, res_data); end
   endtask

   task automatic test_all_requesting();
      logic [2:0] gseq [4];
      logic [1:0] iseq [4];
      logic [7:0] dseq [4];
      gseq = '{3'b001, 3'b010, 3'b100, 3'b001};
      iseq = '{2'd0, 2'd1, 2'd2, 2'd0};
      dseq = '{8'h02, 8'h04, 8'h06, 8'h02};
      reset_dut();
      set_ops(0, 8'h01, 8'h01);
      set_ops(1, 8'h02, 8'h02);
      set_ops(2, 8'h03, 8'h03);
      req = 3'b111;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_vec++; if (gnt !== gseq[c]) begin n_err++; $display("FAIL rr_gnt[%0d] got %b want %b", c, gnt, gseq[c]); end
         tick(gdum);
         n_vec++; if (res_valid !== 1'b1 || res_id !== iseq[c] || res_data !== dseq[c]) begin
            n_err++; $display("FAIL rr_res[%0d] got v=%b id=%0d d=%h want 1/%0d/%h", c, res_valid, res_id, res_data, iseq[c], dseq[c]); end
      end
      req = 3'b000;
   endtask

   task automatic test_backpressure();
      reset_dut();
      set_ops(0, 8'h40, 8'h01);
      set_ops(1, 8'h10, 8'h05);
      set_ops(2, 8'h21, 8'h03);
      req = 3'b010;
      #1;
      n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL bp_first_gnt got %b want 010", gnt); end
      tick(gdum);
      req       = 3'b101;
      res_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL bp_stall_gnt[%0d] got %b want 000", c, gnt); end
         tick(gdum);
         n_vec++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 8'h15) begin
            n_err++; $display("FAIL bp_stall_res[%0d] got v=%b id=%0d d=%h want 1/1/15", c, res_valid, res_id, res_data); end
      end
      res_ready = 1'b1;
      #1;
      n_vec++; if (gnt !== 3'b100) begin n_err++; $display("FAIL bp_resume_gnt got %b want 100", gnt); end
      tick(gdum);
      req = 3'b001;
      n_vec++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== 8'h24) begin
         n_err++; $display("FAIL bp_resume_res got v=%b id=%0d d=%h want 1/2/24", res_valid, res_id, res_data); end
      req = 3'b000;
   endtask

   task automatic test_wrap();
      logic [7:0] av [3];
      logic [7:0] bv [3];
      logic [7:0] sv [3];
      av = '{8'hFF, 8'h80, 8'h7F};
      bv = '{8'h01, 8'h80, 8'h01};
      sv = '{8'h00, 8'h00, 8'h80};
      reset_dut();
      req = 3'b001;
      for (int c = 0; c < 3; c++) begin
         set_ops(0, av[c], bv[c]);
         tick(gdum);
         n_vec++; if (res_valid !== 1'b1 || res_data !== sv[c]) begin
            n_err++; $display("FAIL wrap[%0d] got v=%b d=%h want 1/%h", c, res_valid, res_data, sv[c]); end
      end
      req = 3'b000;
   endtask

   task automatic test_ptr_idle();
      reset_dut();
      set_ops(0, 8'h01, 8'h02);
      set_ops(1, 8'h03, 8'h04);
      set_ops(2, 8'h05, 8'h06);
      req = 3'b100;
      #1;
      n_vec++; if (gnt !== 3'b100) begin n_err++; $display("FAIL idle_first_gnt got %b want 100", gnt); end
      tick(gdum);
      req = 3'b000;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL idle_gnt[%0d] got %b want 000", c, gnt); end
         tick(gdum);
      end
      n_vec++; if (res_valid !== 1'b0 || res_id !== 2'd2 || res_data !== 8'h0B) begin
         n_err++; $display("FAIL idle_clear got v=%b id=%0d d=%h want 0/2/0b", res_valid, res_id, res_data); end
      req = 3'b011;
      #1;
      n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL idle_wrap_gnt0 got %b want 001", gnt); end
      tick(gdum);
      #1;
      n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL idle_wrap_gnt1 got %b want 010", gnt); end
      tick(gdum);
      req = 3'b000;
   endtask

   task automatic test_reset_mid();
      reset_dut();
      res_ready = 1'b0;
      set_ops(0, 8'h05, 8'h06);
      set_ops(1, 8'h11, 8'h22);
      set_ops(2, 8'h33, 8'h44);
      req = 3'b001;
      tick(gdum);
      n_vec++; if (res_valid !== 1'b1 || res_data !== 8'h0B) begin
         n_err++; $display("FAIL mid_pending got v=%b d=%h want 1/0b", res_valid, res_data); end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (res_valid !== 1'b0 || res_id !== 2'd0 || res_data !== 8'h00 || gnt !== 3'b000) begin
         n_err++; $display("FAIL mid_async got v=%b id=%0d d=%h g=%b want 0/0/00/000", res_valid, res_id, res_data, gnt); end
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      model_reset();
      req       = 3'b110;
      res_ready = 1'b1;
      #1;
      n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL mid_release_gnt got %b want 010", gnt); end
      tick(gdum);
      req = 3'b000;
      n_vec++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 8'h33) begin
         n_err++; $display("FAIL mid_release_res got v=%b id=%0d d=%h want 1/1/33", res_valid, res_id, res_data); end
   endtask

   task automatic test_random();
      int g, gg;
      logic [7:0] ea, eb;
      reset_dut();
      for (int i = 0; i < NREQ; i++) set_ops(i, 8'($urandom), 8'($urandom));
      for (int c = 0; c < 400; c++) begin
         res_ready = ($urandom_range(0, 3) != 0);
         #1;
         g  = exp_grant();
         ea = (g >= 0) ? opa(g) : 8'h00;
         eb = (g >= 0) ? opb(g) : 8'h00;
         n_vec++; if (gnt !== onehot(g)) begin n_err++; $display("FAIL rnd_gnt[%0d] got %b want %b", c, gnt, onehot(g)); end
         n_vec++; if (add_a !== ea || add_b !== eb) begin
            n_err++; $display("FAIL rnd_add[%0d] got %h/%h want %h/%h", c, add_a, add_b, ea, eb); end
         tick(gg);
         n_vec++; if (res_valid !== m_valid || res_id !== 2'(m_id) || res_data !== m_data) begin
            n_err++; $display("FAIL rnd_res[%0d] got v=%b id=%0d d=%h want %b/%0d/%h", c, res_valid, res_id, res_data, m_valid, m_id, m_data); end
         // A requester may change only when idle or just granted; otherwise it holds.
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || i == gg) begin
               req[i] = 1'($urandom_range(0, 1));
               set_ops(i, 8'($urandom), 8'($urandom));
            end
         end
      end
      req = 3'b000;
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = '0;
      op_a      = '0;
      op_b      = '0;
      res_ready = 1'b1;
      model_reset();
      test_reset();
      test_single();
      test_all_requesting();
      test_backpressure();
      test_wrap();
      test_ptr_idle();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
